sram_like_slave: RTL and testbench

Responder for the sram-like bus (req / addr_ok / data_ok) driven by the pipeline fetch and memory stages. It accepts requests, issues them to a synchronous single-port RAM with 1-cycle read latency, and returns exactly one in-order data_ok per accepted request. It never drops or cancels an accepted request. The initiators depend on this to drain responses after a pipeline flush. It sits between one sram-like master port and one RAM macro.

---
 rtl/sram_like_pkg.sv | 31 +++
 rtl/sram_like_resp_fifo.sv | 76 +++++++
 rtl/sram_like_slave.sv | 159 +++++++++++++++
 tb/tb_sram_like_slave.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// ---------------------------------------------------------------------------
// sram_like_pkg
//
// Shared definitions for the sram-like bus responder:
//   DATA_W     - bus / RAM data width (32)
//   size_e     - access size encodings carried on the 'size' port
//   LFSR_SEED  - reset value of the optional stall-generation LFSR
//   LFSR_TAPS  - tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   lfsr_next  - one Fibonacci step of that LFSR
//
// The LFSR items are only referenced when SRAM_LIKE_DELAY_EN is defined.
// ---------------------------------------------------------------------------
package sram_like_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Shift left, feedback bit is the XOR of the tapped bits.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// ---------------------------------------------------------------------------
// sram_like_resp_fifo
//
// Synchronous FIFO holding read/write responses that could not be returned
// in the cycle the RAM produced them.
//
// Parameters:
//   DEPTH  - number of entries (power of two, >= 2)
//   WIDTH  - entry width
// Ports:
//   clk        in   clock
//   resetn     in   synchronous active-low reset, empties the FIFO
//   push       in   write push_data (ignored when full)
//   push_data  in   WIDTH  entry to store
//   pop        in   drop the head entry (ignored when empty)
//   pop_data   out  WIDTH  current head entry
//   empty      out  no entries stored
//   full       out  DEPTH entries stored
// ---------------------------------------------------------------------------
module sram_like_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[PW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sram_like_slave.sv
// ---------------------------------------------------------------------------
// sram_like_slave
//
// Responder for the sram-like bus (req / addr_ok / data_ok). Accepted
// requests go straight to a synchronous single-port RAM (1-cycle read
// latency); exactly one in-order data_ok is returned per accepted request,
// and accepted requests are never dropped.
//
// Parameters:
//   DEPTH  - max outstanding requests (power of two, >= 2)
//   AW     - RAM word-address width
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   req, wr, size        request valid, write flag, access size (informational)
//   wstrb, addr, wdata   byte enables, byte address, write data
//   addr_ok              request accepted this cycle (req & addr_ok)
//   data_ok, rdata       response valid, read data (0 for writes / idle)
//   ram_en, ram_we       RAM enable, RAM byte write enables
//   ram_addr, ram_wdata  RAM word address, RAM write data
//   ram_rdata            RAM read data, valid the cycle after ram_en
//
// Configuration macro: SRAM_LIKE_DELAY_EN
//   When defined, an 8-bit LFSR injects pseudo-random accept and return
//   stalls. When undefined, no LFSR is built and both stalls are 0.
// ---------------------------------------------------------------------------
module sram_like_slave
    import sram_like_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              pend_wr_q, pend_wr_d;

    logic              acc_stall;
    logic              ret_stall;
    logic              accept;

    logic [DATA_W-1:0] pend_data;
    logic              bypass;
    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              fifo_full;

`ifdef SRAM_LIKE_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign acc_stall = (lfsr_q[1:0] == 2'b00);
    assign ret_stall = (lfsr_q[3:2] == 2'b00);
`else
    assign acc_stall = 1'b0;
    assign ret_stall = 1'b0;
`endif

    // addr_ok looks only at registered state so a data_ok in the full cycle
    // cannot open the door in that same cycle.
    assign addr_ok = resetn & (cnt_q < CNT_MAX) & ~acc_stall;
    assign accept  = req & addr_ok;

    always_comb begin
        ram_en    = accept;
        ram_we    = (accept && wr) ? wstrb : 4'b0000;
        ram_addr  = addr[AW+1:2];
        ram_wdata = wdata;
    end

    // Response selection: a queued FIFO entry always goes before the RAM
    // result of this cycle, which otherwise bypasses the FIFO when it can.
    always_comb begin
        pend_data = pend_wr_q ? '0 : ram_rdata;
        fifo_pop  = resetn & ~fifo_empty & ~ret_stall;
        bypass    = resetn & pend_q & fifo_empty & ~ret_stall;
        fifo_push = resetn & pend_q & ~bypass;
        data_ok   = fifo_pop | bypass;
        if (fifo_pop) begin
            rdata = fifo_head;
        end else if (bypass) begin
            rdata = pend_data;
        end else begin
            rdata = '0;
        end
    end

    always_comb begin
        cnt_d     = cnt_q + CW'(accept) - CW'(data_ok);
        pend_d    = accept;
        pend_wr_d = accept & wr;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            pend_wr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    // Holds at most DEPTH-1 entries while a result is pending, so it never
    // overflows given cnt <= DEPTH.
    sram_like_resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_resp_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data (pend_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Address bits outside the word index, the size field and the FIFO full
    // flag are intentionally not used by the datapath.
    logic unused_bits;
    assign unused_bits = ^{size, addr[1:0], addr[31:AW+2], fifo_full};

endmodule

// File: tb/tb_sram_like_slave.sv
module tb_sram_like_slave;

    localparam int DEPTH = 4;
    localparam int AW    = 16;

    logic          clk;
    logic          resetn;
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [3:0]    wstrb;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [31:0]   rdata;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    int cmp_count    = 0;
    int err_count    = 0;
    int bench_cnt    = 0;
    int max_cnt      = 0;
    int run_len      = 0;
    int max_run      = 0;
    int accept_count = 0;
    int resp_count   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mem [0:(1<<AW)-1];

    logic [31:0] stream_tab [8] = '{
        32'h0280_0000, 32'h1111_0101, 32'h2222_0202, 32'h3333_0303,
        32'h4444_0404, 32'h5555_0505, 32'h6666_0606, 32'h7777_0707
    };

    sram_like_slave #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .wstrb     (wstrb),
        .addr      (addr),
        .wdata     (wdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, read-before-write, 1-cycle latency.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (data_ok) begin
            if (exp_q.size() == 0) checkOutput("spurious_data_ok", 32'd1, 32'd0);
            else checkOutput("rdata", rdata, exp_q.pop_front());
            resp_count++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            checkOutput("rdata_idle", rdata, 32'd0);
            run_len = 0;
        end
        if (!resetn) checkOutput("addr_ok_in_reset", 32'(addr_ok), 32'd0);
        if (bench_cnt == DEPTH) checkOutput("addr_ok_when_full", 32'(addr_ok), 32'd0);
        if (bench_cnt > DEPTH) checkOutput("outstanding_overflow", 32'(bench_cnt), 32'(DEPTH));
        if (!resetn) begin
            bench_cnt = 0;
        end else begin
            if (req && addr_ok) begin
                bench_cnt++;
                accept_count++;
            end
            if (data_ok) bench_cnt--;
        end
        if (bench_cnt > max_cnt) max_cnt = bench_cnt;
    end

    // Issue one request and hold it until accepted; expected response is
    // queued in the cycle the handshake is seen. Called at posedge+1.
    task automatic applyStimulus(input logic w, input logic [3:0] strb, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] exp_val);
        bit done = 0;
        req   = 1'b1;
        wr    = w;
        wstrb = strb;
        addr  = a;
        wdata = d;
        size  = 2'd2;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (addr_ok) begin
                exp_q.push_back(exp_val);
                checkOutput("ram_en", 32'(ram_en), 32'd1);
                checkOutput("ram_addr", 32'(ram_addr), 32'(a[AW+1:2]));
                checkOutput("ram_we", 32'(ram_we), w ? 32'(strb) : 32'd0);
                if (w) checkOutput("ram_wdata", ram_wdata, d);
                done = 1;
            end else begin
                checkOutput("ram_en_no_accept", 32'(ram_en), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            req = 1'b0;
        end
    endtask

    task automatic idleCycle();
        req   = 1'b0;
        wr    = 1'b0;
        wstrb = 4'b0000;
        @(posedge clk);
        #1;
    endtask

    task automatic drainResponses();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = stream_tab[i];
        for (int i = 0; i < 32; i++) mem[16 + i] = 32'hC0DE_0000 | 32'(i);
        mem[16'h100] = 32'h1122_3344;
        mem[16'h101] = 32'h0000_0000;
        mem[16'h102] = 32'h1234_5678;
        ram_rdata = '0;
        resetn = 1'b0;
        req    = 1'b0;
        wr     = 1'b0;
        size   = 2'd0;
        wstrb  = 4'b0000;
        addr   = '0;
        wdata  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_data_ok", 32'(data_ok), 32'd0);
        checkOutput("reset_ram_en", 32'(ram_en), 32'd0);
        checkOutput("reset_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
`ifndef SRAM_LIKE_DELAY_EN
        @(negedge clk);
        checkOutput("addr_ok_idle", 32'(addr_ok), 32'd1);
        @(posedge clk);
        #1;
`endif

        $display("[TB] single read");
        applyStimulus(1'b0, 4'h0, 32'h1c00_0000, 32'h0, 32'h0280_0000);
        req = 1'b0;
`ifndef SRAM_LIKE_DELAY_EN
        @(negedge clk);
        checkOutput("single_read_latency", 32'(data_ok), 32'd1);
        @(posedge clk);
        #1;
`endif
        drainResponses();
        idleCycle();
        checkOutput("single_read_cnt", 32'(bench_cnt), 32'd0);

        $display("[TB] write merge");
        applyStimulus(1'b1, 4'b0011, 32'h0000_0400, 32'hAABB_CCDD, 32'h0);
        applyStimulus(1'b0, 4'b0000, 32'h0000_0400, 32'h0, 32'h1122_CCDD);
        applyStimulus(1'b1, 4'b1000, 32'h0000_0404, 32'h5A5A_5A5A, 32'h0);
        applyStimulus(1'b0, 4'b0000, 32'h0000_0404, 32'h0, 32'h5A00_0000);
        applyStimulus(1'b1, 4'b1111, 32'h0000_0408, 32'hDEAD_BEEF, 32'h0);
        applyStimulus(1'b0, 4'b0000, 32'h0000_0408, 32'h0, 32'hDEAD_BEEF);
        idleCycle();
        drainResponses();

        $display("[TB] streaming");
        max_cnt = 0;
        max_run = 0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'h0, 32'(i * 4), 32'h0, stream_tab[i]);
        idleCycle();
        drainResponses();
        idleCycle();
`ifndef SRAM_LIKE_DELAY_EN
        checkOutput("stream_max_cnt", 32'(max_cnt), 32'd1);
        checkOutput("stream_back_to_back", 32'(max_run), 32'd8);
`endif

        $display("[TB] continuous requests");
        max_cnt = 0;
        for (int k = 0; k < 150; k++)
            applyStimulus(1'b0, 4'h0, 32'((16 + k % 32) * 4), 32'h0, 32'hC0DE_0000 | 32'(k % 32));
        idleCycle();
        drainResponses();
        idleCycle();
        checkOutput("accepts_vs_responses", 32'(resp_count), 32'(accept_count));

        $display("[TB] reset mid-flight");
        applyStimulus(1'b0, 4'h0, 32'h0000_0000, 32'h0, stream_tab[0]);
        applyStimulus(1'b0, 4'h0, 32'h0000_0004, 32'h0, stream_tab[1]);
        req    = 1'b0;
        resetn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("midrst_addr_ok", 32'(addr_ok), 32'd0);
        checkOutput("midrst_data_ok", 32'(data_ok), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (4) idleCycle();
        applyStimulus(1'b0, 4'h0, 32'h0000_0008, 32'h0, stream_tab[2]);
        req = 1'b0;
`ifndef SRAM_LIKE_DELAY_EN
        @(negedge clk);
        checkOutput("post_reset_latency", 32'(data_ok), 32'd1);
        @(posedge clk);
        #1;
`endif
        drainResponses();
        repeat (3) idleCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
